// File: rtl/cordic_angle_sequencer_if.sv
// Sample stream from the angle sequencer to the CORDIC stage.
// Master drives valid/data, slave drives ready.
interface cordic_angle_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] angle;
  logic [WIDTH-1:0] x_start;
  logic [WIDTH-1:0] y_start;
  logic [CNT_W-1:0] sample_idx;

  modport master (
    output out_valid,
    output angle,
    output x_start,
    output y_start,
    output sample_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  angle,
    input  x_start,
    input  y_start,
    input  sample_idx,
    output out_ready
  );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// Angle sweep generator feeding the CORDIC sin/cos stage.
// Emits start + k*step wrapped to [0, 2*pi) over valid/ready.
module cordic_angle_sequencer #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      CNT_W  = 16,
  parameter logic [WIDTH-1:0] TWO_PI = 32'd1686629713,
  parameter logic [WIDTH-1:0] K_INV  = 32'd163008218
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_angle,
  input  logic [WIDTH-1:0] step,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  cordic_angle_sequencer_if.master out_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;

  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_angle;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_step;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_num;

  logic             w_xfer;
  logic             w_last;
  logic             w_load;
  logic             w_adv;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap;
  logic [WIDTH-1:0] w_first;

  assign w_xfer = r_valid & out_if.out_ready;
  assign w_last = (r_idx == r_num - CNT_W'(1));
  assign w_sum  = {1'b0, r_angle} + {1'b0, r_step};

  // step < TWO_PI keeps a single subtraction sufficient
  assign w_wrap = (w_sum >= {1'b0, TWO_PI})
                ? w_sum - {1'b0, TWO_PI}
                : w_sum;

  assign w_first = (start_angle >= TWO_PI)
                 ? start_angle - TWO_PI
                 : start_angle;

  assign w_load = (r_state == S_IDLE) & start
                & (num_samples != '0);
  assign w_adv  = (r_state == S_RUN) & !abort
                & w_xfer & !w_last;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_samples == '0) w_state_n = S_DONE;
          else                   w_state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)
          w_state_n = S_IDLE;
        else if (w_xfer && w_last)
          w_state_n = S_DONE;
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_valid <= (w_state_n == S_RUN);
      r_busy  <= (w_state_n == S_RUN);
      r_done  <= (w_state_n == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_angle <= '0;
      r_x     <= '0;
      r_step  <= '0;
      r_idx   <= '0;
      r_num   <= '0;
    end else if (w_load) begin
      r_angle <= w_first;
      r_x     <= K_INV;
      r_step  <= step;
      r_idx   <= '0;
      r_num   <= num_samples;
    end else if (w_adv) begin
      r_angle <= w_wrap[WIDTH-1:0];
      r_idx   <= r_idx + CNT_W'(1);
    end
  end

  assign out_if.out_valid  = r_valid;
  assign out_if.angle      = r_angle;
  assign out_if.x_start    = r_x;
  assign out_if.y_start    = '0;
  assign out_if.sample_idx = r_idx;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed bench for cordic_angle_sequencer.
// Linear steps with immediate assertions at each check.
module tb_cordic_angle_sequencer;

  localparam int unsigned W = 32;
  localparam int unsigned C = 16;
  localparam logic [31:0] TP = 32'd1686629713;
  localparam logic [31:0] KI = 32'd163008218;
  localparam logic [31:0] ST = 32'd421658414;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  start_angle = '0;
  logic [W-1:0]  step = '0;
  logic [C-1:0]  num_samples = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_ang [5];

  cordic_angle_sequencer_if #(.WIDTH(W), .CNT_W(C)) sif ();

  cordic_angle_sequencer #(
    .WIDTH(W), .CNT_W(C), .TWO_PI(TP), .K_INV(KI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_angle (start_angle),
    .step        (step),
    .num_samples (num_samples),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .out_if      (sif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int cyc;
    exp_ang[0] = 32'd0;
    exp_ang[1] = 32'd421658414;
    exp_ang[2] = 32'd843316828;
    exp_ang[3] = 32'd1264975242;
    exp_ang[4] = 32'd3943;
    sif.out_ready = 1'b0;

    // reset state
    #3;
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_angle", sif.angle, 0);
    chk("rst_x", sif.x_start, 0);
    chk("rst_idx", sif.sample_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full-rate sweep with wrap
    start = 1'b1; start_angle = 0; step = ST;
    num_samples = 5; sif.out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", sif.out_valid, 1);
      chk("t1_angle", sif.angle, exp_ang[i]);
      chk("t1_idx", sif.sample_idx, i);
      chk("t1_x", sif.x_start, KI);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_valid_off", sif.out_valid, 0);
    chk("t1_busy_off", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // 2: backpressure 1,0,0,1,...
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 40) begin
      sif.out_ready = (cyc % 3 == 0);
      chk("t2_valid", sif.out_valid, 1);
      chk("t2_angle", sif.angle, exp_ang[k]);
      chk("t2_idx", sif.sample_idx, k);
      chk("t2_nodone", done, 0);
      if (sif.out_ready) k++;
      cyc++;
      tick();
    end
    chk("t2_transfers", k, 5);
    chk("t2_done", done, 1);
    chk("t2_valid_off", sif.out_valid, 0);
    sif.out_ready = 1'b1;
    tick();

    // 3: zero samples
    start = 1'b1; num_samples = 0;
    tick();
    start = 1'b0;
    chk("t3_valid", sif.out_valid, 0);
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 1);
    tick();
    chk("t3_done_off", done, 0);
    chk("t3_valid2", sif.out_valid, 0);

    // 4: start angle above 2*pi, zero step
    start = 1'b1; start_angle = TP + 32'd100;
    step = 0; num_samples = 2;
    tick();
    start = 1'b0;
    chk("t4_angle0", sif.angle, 100);
    chk("t4_x", sif.x_start, KI);
    chk("t4_y", sif.y_start, 0);
    tick();
    chk("t4_angle1", sif.angle, 100);
    chk("t4_idx1", sif.sample_idx, 1);
    tick();
    chk("t4_done", done, 1);
    tick();

    // 5: abort at idx 2 of 8
    start = 1'b1; start_angle = 0;
    step = ST; num_samples = 8;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t5_idx2", sif.sample_idx, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid", sif.out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_nodone", done, 0);
    start = 1'b1; start_angle = 5; num_samples = 1;
    tick();
    start = 1'b0;
    chk("t5_restart", sif.out_valid, 1);
    chk("t5_angle", sif.angle, 5);
    chk("t5_idx", sif.sample_idx, 0);
    tick();
    chk("t5_done", done, 1);
    tick();

    // 6: start ignored while busy, async reset
    start = 1'b1; start_angle = 0;
    step = ST; num_samples = 4;
    tick();
    start_angle = 777;
    tick();
    start = 1'b0;
    chk("t6_ign_angle", sif.angle, exp_ang[1]);
    chk("t6_ign_idx", sif.sample_idx, 1);
    sif.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", sif.out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_angle", sif.angle, 0);
    chk("t6_x", sif.x_start, 0);
    chk("t6_idx", sif.sample_idx, 0);
    chk("t6_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle", sif.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
